// File: rtl/reminder_alarm_ctrl.sv
// Medication reminder controller: counts down a programmable interval in
// seconds, raises an alarm, and counts doses that time out unacknowledged.
module reminder_alarm_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 60,
    parameter int unsigned IW          = 12
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Tick_1s,
    input  logic          Ack_in,
    input  logic          Start_in,
    input  logic          Stop_in,
    input  logic [IW-1:0] Interval_in,
    output logic          Alarm_out,
    output logic          Missed_pulse,
    output logic [3:0]    Missed_cnt,
    output logic [IW-1:0] Remaining
);

    localparam logic [7:0] AckTo = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_Idle  = 2'd0,
        S_Count = 2'd1,
        S_Alarm = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] interval_q, interval_d;
    logic [IW-1:0] remaining_q, remaining_d;
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic          alarm_q, alarm_d;
    logic          missed_pulse_q, missed_pulse_d;
    logic [3:0]    missed_cnt_q, missed_cnt_d;

    logic load_ok;
    logic tick_last;
    logic timed_out;

    // A zero interval never arms the reminder.
    assign load_ok   = Start_in && (Interval_in != '0);
    assign tick_last = Tick_1s && (remaining_q == IW'(1));
    assign timed_out = Tick_1s && ((to_cnt_q + 8'd1) == AckTo);

    // State and registered outputs, synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= S_Idle;
            interval_q     <= '0;
            remaining_q    <= '0;
            to_cnt_q       <= '0;
            alarm_q        <= 1'b0;
            missed_pulse_q <= 1'b0;
            missed_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            interval_q     <= interval_d;
            remaining_q    <= remaining_d;
            to_cnt_q       <= to_cnt_d;
            alarm_q        <= alarm_d;
            missed_pulse_q <= missed_pulse_d;
            missed_cnt_q   <= missed_cnt_d;
        end
    end

    // Next-state logic; priority Stop > Start > Ack > Tick.
    always_comb begin
        state_d = state_q;
        if (Stop_in) begin
            state_d = S_Idle;
        end else begin
            case (state_q)
                S_Idle: begin
                    if (load_ok) state_d = S_Count;
                end
                S_Count: begin
                    if (Start_in)       state_d = load_ok ? S_Count : S_Idle;
                    else if (tick_last) state_d = S_Alarm;
                end
                S_Alarm: begin
                    if (Start_in)                   state_d = load_ok ? S_Count : S_Idle;
                    else if (Ack_in || timed_out)   state_d = S_Count;
                end
                default: state_d = S_Idle;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        interval_d     = interval_q;
        remaining_d    = remaining_q;
        to_cnt_d       = to_cnt_q;
        alarm_d        = alarm_q;
        missed_pulse_d = 1'b0;
        missed_cnt_d   = missed_cnt_q;
        if (Stop_in) begin
            // Missed count survives a stop; everything else is cleared.
            interval_d  = '0;
            remaining_d = '0;
            to_cnt_d    = '0;
            alarm_d     = 1'b0;
        end else begin
            case (state_q)
                S_Idle: begin
                    if (load_ok) begin
                        interval_d  = Interval_in;
                        remaining_d = Interval_in;
                        to_cnt_d    = '0;
                    end
                end
                S_Count, S_Alarm: begin
                    if (Start_in) begin
                        interval_d  = Interval_in;
                        remaining_d = Interval_in;
                        to_cnt_d    = '0;
                        alarm_d     = 1'b0;
                    end else if (state_q == S_Count) begin
                        // Ack has no meaning while counting, so a tick still applies.
                        if (Tick_1s && (remaining_q != '0)) begin
                            remaining_d = remaining_q - IW'(1);
                            if (tick_last) begin
                                alarm_d  = 1'b1;
                                to_cnt_d = '0;
                            end
                        end
                    end else if (Ack_in) begin
                        // An ack on the timing-out tick still counts as acknowledged.
                        alarm_d     = 1'b0;
                        remaining_d = interval_q;
                        to_cnt_d    = '0;
                    end else if (timed_out) begin
                        alarm_d        = 1'b0;
                        missed_pulse_d = 1'b1;
                        if (missed_cnt_q != 4'hF) missed_cnt_d = missed_cnt_q + 4'd1;
                        remaining_d    = interval_q;
                        to_cnt_d       = '0;
                    end else if (Tick_1s) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                end
                default: begin
                    interval_d   = '0;
                    remaining_d  = '0;
                    to_cnt_d     = '0;
                    alarm_d      = 1'b0;
                    missed_cnt_d = '0;
                end
            endcase
        end
    end

    assign Alarm_out    = alarm_q;
    assign Missed_pulse = missed_pulse_q;
    assign Missed_cnt   = missed_cnt_q;
    assign Remaining    = remaining_q;

endmodule

// File: tb/tb_reminder_alarm_ctrl.sv
// Bench for reminder_alarm_ctrl: directed scenarios plus random stimulus
// compared each cycle against a behavioural model of the reminder.
module tb_reminder_alarm_ctrl;

    localparam int IW = 12;
    localparam int AckTimeout = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Tick_1s = 1'b0;
    logic          Ack_in = 1'b0;
    logic          Start_in = 1'b0;
    logic          Stop_in = 1'b0;
    logic [IW-1:0] Interval_in = '0;
    logic          Alarm_out;
    logic          Missed_pulse;
    logic [3:0]    Missed_cnt;
    logic [IW-1:0] Remaining;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 counting, 2 alarming.
    int m_mode = 0, m_rem = 0, m_ivl = 0, m_wait = 0, m_missed = 0;
    bit m_alarm = 0, m_pulse = 0;

    reminder_alarm_ctrl #(
        .ACK_TIMEOUT(AckTimeout),
        .IW         (IW)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Tick_1s     (Tick_1s),
        .Ack_in      (Ack_in),
        .Start_in    (Start_in),
        .Stop_in     (Stop_in),
        .Interval_in (Interval_in),
        .Alarm_out   (Alarm_out),
        .Missed_pulse(Missed_pulse),
        .Missed_cnt  (Missed_cnt),
        .Remaining   (Remaining)
    );

    always #5 Clk = ~Clk;

    task automatic model_update(input bit rst, stop, start, ack, tick, input int ivl);
        m_pulse = 0;
        if (rst) begin
            m_mode = 0; m_rem = 0; m_ivl = 0; m_wait = 0; m_missed = 0; m_alarm = 0;
        end else if (stop) begin
            m_mode = 0; m_rem = 0; m_ivl = 0; m_wait = 0; m_alarm = 0;
        end else if (start) begin
            if (ivl != 0) begin
                m_mode = 1; m_rem = ivl; m_ivl = ivl; m_wait = 0; m_alarm = 0;
            end else if (m_mode != 0) begin
                m_mode = 0; m_rem = 0; m_ivl = 0; m_wait = 0; m_alarm = 0;
            end
        end else if (m_mode == 2) begin
            if (ack) begin
                m_mode = 1; m_alarm = 0; m_rem = m_ivl; m_wait = 0;
            end else if (tick) begin
                m_wait++;
                if (m_wait == AckTimeout) begin
                    m_mode = 1; m_alarm = 0; m_pulse = 1; m_rem = m_ivl; m_wait = 0;
                    m_missed = (m_missed < 15) ? m_missed + 1 : 15;
                end
            end
        end else if (m_mode == 1 && tick && m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_mode = 2; m_alarm = 1; m_wait = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (Alarm_out === m_alarm) else begin
            errors++;
            $error("FAIL %s Alarm_out got %0b want %0b", tag, Alarm_out, m_alarm);
        end
        checks++;
        assert (Missed_pulse === m_pulse) else begin
            errors++;
            $error("FAIL %s Missed_pulse got %0b want %0b", tag, Missed_pulse, m_pulse);
        end
        checks++;
        assert (Missed_cnt === 4'(m_missed)) else begin
            errors++;
            $error("FAIL %s Missed_cnt got %0d want %0d", tag, Missed_cnt, m_missed);
        end
        checks++;
        assert (Remaining === IW'(m_rem)) else begin
            errors++;
            $error("FAIL %s Remaining got %0d want %0d", tag, Remaining, m_rem);
        end
    endtask

    // Apply one cycle of inputs, advance model on the edge, check 1 time unit later.
    task automatic step(input bit rst, stop, start, ack, tick, input int ivl, input string tag);
        Rst = rst; Stop_in = stop; Start_in = start; Ack_in = ack; Tick_1s = tick;
        Interval_in = IW'(ivl);
        @(posedge Clk);
        model_update(rst, stop, start, ack, tick, ivl);
        #1;
        check_all(tag);
        Rst = 0; Stop_in = 0; Start_in = 0; Ack_in = 0; Tick_1s = 0;
    endtask

    initial begin
        // Reset and zero-interval start.
        step(1, 0, 0, 0, 0, 0, "reset");
        step(0, 0, 1, 0, 0, 0, "start_zero_idle");
        step(0, 0, 0, 1, 1, 0, "idle_ack_tick");

        // Countdown 3,2,1,0 then alarm.
        step(0, 0, 1, 0, 0, 3, "start3");
        step(0, 0, 0, 0, 1, 0, "tick1");
        step(0, 0, 0, 0, 0, 0, "gap");
        step(0, 0, 0, 1, 1, 0, "tick2_ack_ignored");
        step(0, 0, 0, 0, 1, 0, "tick3_alarm");
        step(0, 0, 0, 0, 0, 0, "alarm_hold");

        // Acknowledge reloads.
        step(0, 0, 0, 1, 0, 0, "ack");

        // Timeout after two ticks.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "count_to_alarm");
        step(0, 0, 0, 0, 1, 0, "wait1");
        step(0, 0, 0, 0, 1, 0, "timeout");
        step(0, 0, 0, 0, 0, 0, "pulse_drop");

        // Ack coincident with the timing-out tick.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "count_to_alarm2");
        step(0, 0, 0, 0, 1, 0, "wait1b");
        step(0, 0, 0, 1, 1, 0, "ack_on_timeout");

        // Saturation of the missed counter.
        step(0, 0, 1, 0, 0, 1, "start1");
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 0, 0, 1, 0, "sat_alarm");
            step(0, 0, 0, 0, 1, 0, "sat_wait");
            step(0, 0, 0, 0, 1, 0, "sat_timeout");
        end
        step(0, 1, 0, 0, 0, 0, "stop_keeps_missed");

        // Reset mid-alarm, then zero start.
        step(0, 0, 1, 0, 0, 2, "start2");
        step(0, 0, 0, 0, 1, 0, "t1");
        step(0, 0, 0, 0, 1, 0, "t2_alarm");
        step(1, 0, 0, 0, 0, 0, "reset_in_alarm");
        step(0, 0, 1, 0, 0, 0, "start_zero_after_reset");

        // Start in alarm with new interval, and with zero interval.
        step(0, 0, 1, 0, 0, 1, "start1b");
        step(0, 0, 0, 0, 1, 0, "alarm_b");
        step(0, 0, 1, 0, 0, 4, "restart_in_alarm");
        step(0, 0, 0, 0, 1, 0, "dec_after_restart");
        step(0, 1, 1, 1, 1, 5, "stop_wins");

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), int'($urandom_range(0, 4)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
